thread_fetch_scheduler: RTL and testbench

// - Fine-grained round-robin scheduler for the 4-thread MIPS front end; picks one thread per cycle
//   and drives the thread select used by fetch and by the per-thread gshare branch predictor.
// - Consumes ALU-stage misprediction flags; issues per-thread flush pulses and suspends the

---
 rtl/mips_sched_pkg.sv | 19 +
 rtl/rr_picker.sv | 28 ++
 rtl/thread_fetch_scheduler.sv | 134 +++++++++++++
 tb/tb_thread_fetch_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_sched_pkg.sv
// Shared types for the 4-thread fetch scheduler.
// Thread id width, thread state enum and helpers.
package mips_sched_pkg;

  localparam int NUM_THREADS = 4;
  localparam int THREAD_BITS = 2;

  typedef logic [THREAD_BITS-1:0] thread_id_t;

  typedef enum logic [1:0] {
    ACTIVE   = 2'd0,
    PENALTY  = 2'd1,
    DISABLED = 2'd2
  } thread_state_t;

  localparam thread_id_t LAST_ID =
    thread_id_t'(NUM_THREADS - 1);

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority picker: first eligible thread
// strictly after ptr, wrapping, ptr itself last.
module rr_picker
  import mips_sched_pkg::*;
(
  input  logic [NUM_THREADS-1:0] elig,
  input  thread_id_t             ptr,
  output thread_id_t             id,
  output logic                   found
);

  thread_id_t cand;

  // Walk lowest priority first so nearest wins.
  always_comb begin
    id    = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      cand = ptr + thread_id_t'(k);
      if (elig[cand]) begin
        id    = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_fetch_scheduler.sv
// Round-robin fetch scheduler with mispredict penalty.
// Optional perf counters: define SCHED_PERF_CNT_EN.
module thread_fetch_scheduler
  import mips_sched_pkg::*;
#(
  parameter int PENALTY_CYCLES = 3,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset_n,
  input  logic [NUM_THREADS-1:0] i_thread_enable,
  input  logic [NUM_THREADS-1:0] i_thread_wait,
  input  logic                   i_stall,
  input  logic [NUM_THREADS-1:0] i_ALU_mispredict,
`ifdef SCHED_PERF_CNT_EN
  input  thread_id_t             i_cnt_sel,
  output logic [CNT_WIDTH-1:0]   o_cnt_value,
`endif
  output thread_id_t             o_thread,
  output logic                   o_issue_valid,
  output logic [NUM_THREADS-1:0] o_flush,
  output logic [NUM_THREADS-1:0] o_thread_blocked
);

  localparam logic [3:0] PEN_LD =
    4'(PENALTY_CYCLES);

  thread_state_t state [NUM_THREADS];
  logic [3:0]    pen_cnt [NUM_THREADS];

  logic [NUM_THREADS-1:0] accept;
  logic [NUM_THREADS-1:0] elig;
  logic [NUM_THREADS-1:0] blocked;

  thread_id_t ptr;
  thread_id_t pick_id;
  logic       pick_found;

  // Per-thread eligibility and accepted mispredicts.
  always_comb begin
    accept  = '0;
    elig    = '0;
    blocked = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      accept[t] = i_ALU_mispredict[t] &
                  i_thread_enable[t] &
                  (state[t] != DISABLED);
      elig[t] = (state[t] == ACTIVE) &
                i_thread_enable[t] &
                ~i_thread_wait[t] &
                ~i_ALU_mispredict[t];
      blocked[t] = (state[t] != ACTIVE);
    end
  end

  assign o_thread_blocked = blocked;

  rr_picker u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .id    (pick_id),
    .found (pick_found)
  );

  // Thread state machines with penalty countdown.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        state[t]   <= ACTIVE;
        pen_cnt[t] <= '0;
      end
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (!i_thread_enable[t]) begin
          state[t]   <= DISABLED;
          pen_cnt[t] <= '0;
        end else if (accept[t]) begin
          state[t]   <= PENALTY;
          pen_cnt[t] <= PEN_LD;
        end else begin
          unique case (state[t])
            DISABLED: state[t] <= ACTIVE;
            PENALTY: begin
              if (pen_cnt[t] <= 4'd1) begin
                state[t]   <= ACTIVE;
                pen_cnt[t] <= '0;
              end else begin
                pen_cnt[t] <= pen_cnt[t] - 4'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Registered issue slot, pointer and flush.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      o_thread      <= '0;
      o_issue_valid <= 1'b0;
      o_flush       <= '0;
      ptr           <= LAST_ID;
    end else begin
      o_flush <= accept;
      if (!i_stall) begin
        o_issue_valid <= pick_found;
        if (pick_found) begin
          o_thread <= pick_id;
          ptr      <= pick_id;
        end
      end
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_THREADS];

  // Saturating per-thread issue counters.
  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      for (int t = 0; t < NUM_THREADS; t++)
        cnt_q[t] <= '0;
    end else if (o_issue_valid && !i_stall &&
                 cnt_q[o_thread] != '1) begin
      cnt_q[o_thread] <= cnt_q[o_thread] + 1'b1;
    end
  end

  assign o_cnt_value = cnt_q[i_cnt_sel];
`endif

endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Self-checking bench for thread_fetch_scheduler.
// Directed table, hand sequences, random vs model.
module tb_thread_fetch_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] en, wt, mp;
  logic       st;
  logic [1:0] o_thread;
  logic       o_valid;
  logic [3:0] o_flush, o_blk;
`ifdef SCHED_PERF_CNT_EN
  logic [1:0]  sel;
  logic [15:0] o_cnt;
  int          m_cnt [4];
`endif

  int checks = 0;
  int errors = 0;

  int         cyc;
  logic [1:0] m_thread, m_ptr;
  logic       m_valid;
  logic [3:0] m_flush, m_pren, m_blk;
  int         m_pe [4];

  localparam int P = 3;

  always #5 clk = ~clk;

  thread_fetch_scheduler dut (
    .i_Clk            (clk),
    .i_Reset_n        (rst_n),
    .i_thread_enable  (en),
    .i_thread_wait    (wt),
    .i_stall          (st),
    .i_ALU_mispredict (mp),
`ifdef SCHED_PERF_CNT_EN
    .i_cnt_sel        (sel),
    .o_cnt_value      (o_cnt),
`endif
    .o_thread         (o_thread),
    .o_issue_valid    (o_valid),
    .o_flush          (o_flush),
    .o_thread_blocked (o_blk)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h",
               nm, cyc, act, exp);
    end
  endtask

  // Reference model: a thread is eligible when
  // enabled now and last cycle, not waiting, not
  // mispredicting, and not within P cycles of an
  // accepted mispredict.
  task automatic model(input logic rn,
                       input logic [3:0] e,
                       input logic [3:0] w,
                       input logic [3:0] m,
                       input logic s);
    logic [3:0] el, acc;
    logic [1:0] pk;
    bit found;
`ifdef SCHED_PERF_CNT_EN
    if (!rn) begin
      for (int t = 0; t < 4; t++) m_cnt[t] = 0;
    end else if (m_valid && !s &&
                 m_cnt[m_thread] < 65535) begin
      m_cnt[m_thread]++;
    end
`endif
    if (!rn) begin
      m_thread = 0;
      m_valid  = 0;
      m_flush  = 0;
      m_ptr    = 3;
      m_pren   = 4'hF;
      for (int t = 0; t < 4; t++) m_pe[t] = -100;
    end else begin
      for (int t = 0; t < 4; t++) begin
        el[t] = e[t] && !w[t] && m_pren[t] &&
                !m[t] && !(cyc <= m_pe[t]);
        acc[t] = m[t] && e[t] && m_pren[t];
      end
      found = 0;
      pk = 0;
      for (int i = 1; i <= 4; i++) begin
        int c;
        c = (m_ptr + i) % 4;
        if (!found && el[c]) begin
          found = 1;
          pk = 2'(c);
        end
      end
      if (!s) begin
        m_valid = found;
        if (found) begin
          m_thread = pk;
          m_ptr = pk;
        end
      end
      m_flush = acc;
      for (int t = 0; t < 4; t++) begin
        if (acc[t]) m_pe[t] = cyc + P;
        if (!e[t]) m_pe[t] = -100;
      end
      m_pren = e;
    end
    cyc++;
    for (int t = 0; t < 4; t++)
      m_blk[t] = !m_pren[t] || (cyc <= m_pe[t]);
  endtask

  task automatic step(input logic rn,
                      input logic [3:0] e,
                      input logic [3:0] w,
                      input logic [3:0] m,
                      input logic s);
    rst_n = rn;
    en = e;
    wt = w;
    mp = m;
    st = s;
`ifdef SCHED_PERF_CNT_EN
    sel = 2'($urandom_range(0, 3));
`endif
    @(posedge clk);
    model(rn, e, w, m, s);
    #1;
    chk("thread", 32'(o_thread), 32'(m_thread));
    chk("valid", 32'(o_valid), 32'(m_valid));
    chk("flush", 32'(o_flush), 32'(m_flush));
    chk("blocked", 32'(o_blk), 32'(m_blk));
`ifdef SCHED_PERF_CNT_EN
    chk("cnt", 32'(o_cnt), 32'(m_cnt[sel]));
`endif
  endtask

  typedef struct {
    logic [3:0] e;
    logic [3:0] m;
    logic       s;
    logic [1:0] th;
    logic       v;
    logic [3:0] fl;
  } vec_t;

  vec_t tv [32];

  function automatic vec_t mk(logic [3:0] e,
                              logic [3:0] m,
                              logic s,
                              logic [1:0] th,
                              logic v,
                              logic [3:0] fl);
    vec_t r;
    r.e = e; r.m = m; r.s = s;
    r.th = th; r.v = v; r.fl = fl;
    return r;
  endfunction

  initial begin
    cyc = 0;
    rst_n = 0; en = 4'hF; wt = 0; mp = 0; st = 0;
`ifdef SCHED_PERF_CNT_EN
    sel = 0;
`endif
    // rotation, mispredict[2], stall+mp[1],
    // single thread, none, double mp[1]
    tv[0]  = mk(4'hF, 4'h0, 0, 0, 1, 4'h0);
    tv[1]  = mk(4'hF, 4'h0, 0, 1, 1, 4'h0);
    tv[2]  = mk(4'hF, 4'h0, 0, 2, 1, 4'h0);
    tv[3]  = mk(4'hF, 4'h0, 0, 3, 1, 4'h0);
    tv[4]  = mk(4'hF, 4'h4, 0, 0, 1, 4'h4);
    tv[5]  = mk(4'hF, 4'h0, 0, 1, 1, 4'h0);
    tv[6]  = mk(4'hF, 4'h0, 0, 3, 1, 4'h0);
    tv[7]  = mk(4'hF, 4'h0, 0, 0, 1, 4'h0);
    tv[8]  = mk(4'hF, 4'h0, 0, 1, 1, 4'h0);
    tv[9]  = mk(4'hF, 4'h0, 0, 2, 1, 4'h0);
    tv[10] = mk(4'hF, 4'h0, 0, 3, 1, 4'h0);
    tv[11] = mk(4'hF, 4'h0, 1, 3, 1, 4'h0);
    tv[12] = mk(4'hF, 4'h2, 1, 3, 1, 4'h2);
    tv[13] = mk(4'hF, 4'h0, 1, 3, 1, 4'h0);
    tv[14] = mk(4'hF, 4'h0, 0, 0, 1, 4'h0);
    tv[15] = mk(4'hF, 4'h0, 0, 2, 1, 4'h0);
    tv[16] = mk(4'hF, 4'h0, 0, 3, 1, 4'h0);
    tv[17] = mk(4'hF, 4'h0, 0, 0, 1, 4'h0);
    tv[18] = mk(4'hF, 4'h0, 0, 1, 1, 4'h0);
    tv[19] = mk(4'h1, 4'h0, 0, 0, 1, 4'h0);
    tv[20] = mk(4'h1, 4'h0, 0, 0, 1, 4'h0);
    tv[21] = mk(4'h0, 4'h0, 0, 0, 0, 4'h0);
    tv[22] = mk(4'h0, 4'h0, 0, 0, 0, 4'h0);
    tv[23] = mk(4'hF, 4'h0, 0, 0, 0, 4'h0);
    tv[24] = mk(4'hF, 4'h0, 0, 1, 1, 4'h0);
    tv[25] = mk(4'hF, 4'h2, 0, 2, 1, 4'h2);
    tv[26] = mk(4'hF, 4'h0, 0, 3, 1, 4'h0);
    tv[27] = mk(4'hF, 4'h2, 0, 0, 1, 4'h2);
    tv[28] = mk(4'hF, 4'h0, 0, 2, 1, 4'h0);
    tv[29] = mk(4'hF, 4'h0, 0, 3, 1, 4'h0);
    tv[30] = mk(4'hF, 4'h0, 0, 0, 1, 4'h0);
    tv[31] = mk(4'hF, 4'h0, 0, 1, 1, 4'h0);

    #1;
    step(0, 4'hF, 0, 0, 0);
    step(0, 4'hF, 0, 0, 0);
    chk("rst_thread", 32'(o_thread), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_flush", 32'(o_flush), 0);
    chk("rst_blocked", 32'(o_blk), 0);

    for (int i = 0; i < 32; i++) begin
      step(1, tv[i].e, 4'h0, tv[i].m, tv[i].s);
      chk($sformatf("tv%0d_thread", i),
          32'(o_thread), 32'(tv[i].th));
      chk($sformatf("tv%0d_valid", i),
          32'(o_valid), 32'(tv[i].v));
      chk($sformatf("tv%0d_flush", i),
          32'(o_flush), 32'(tv[i].fl));
    end

    step(1, 4'hF, 0, 4'h8, 0);
    step(1, 4'hF, 0, 4'h0, 0);
    chk("pen_blocked", 32'(o_blk), 32'h8);
    step(0, 4'hF, 0, 4'h0, 0);
    chk("midrst_blocked", 32'(o_blk), 0);
    chk("midrst_flush", 32'(o_flush), 0);
    chk("midrst_valid", 32'(o_valid), 0);
    step(1, 4'hF, 0, 4'h0, 0);
    chk("postrst_thread", 32'(o_thread), 0);
    chk("postrst_valid", 32'(o_valid), 1);
    step(1, 4'hF, 0, 4'h0, 0);
    chk("postrst_blocked", 32'(o_blk), 0);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] e, w, m;
      for (int t = 0; t < 4; t++) begin
        e[t] = ($urandom_range(0, 7) != 0);
        w[t] = ($urandom_range(0, 3) == 0);
        m[t] = ($urandom_range(0, 9) == 0);
      end
      step($urandom_range(0, 199) != 0, e, w, m,
           $urandom_range(0, 7) == 0);
    end

`ifdef SCHED_PERF_CNT_EN
    step(0, 4'hF, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step(1, 4'hF, 0, 0, 0);
    step(1, 4'h1, 0, 0, 0);
    for (int i = 0; i < 65540; i++)
      step(1, 4'h1, 0, 0, 0);
    sel = 0;
    #1;
    chk("cnt_sat", 32'(o_cnt), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
